// File: rtl/ir_writer.sv
// Pulse-width IR transmitter: frames a word as a start pulse followed by one
// high pulse per data bit (wide = 1, narrow = 0), each pulse followed by a low gap.
module ir_writer #(
    parameter int N_BITS  = 32,
    parameter int START_W = 15,
    parameter int ONE_W   = 12,
    parameter int ZERO_W  = 6,
    parameter int GAP_W   = 5,
    parameter int CNT_W   = 5
) (
    input  logic              IR_WRITER_CLK,
    input  logic              reset,
    input  logic              send,
    input  logic [N_BITS-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              ir_signal
);

    localparam int BC_W = $clog2(N_BITS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START_HI = 2'd1,
        GAP      = 2'd2,
        BIT_HI   = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [N_BITS-1:0] sr, sr_next;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_next;
    logic [CNT_W-1:0]  width_cnt, width_cnt_next;
    logic              done_next;
    logic              last_cycle;

    assign last_cycle = (width_cnt == CNT_W'(1));

    // Next-state logic; the width counter counts down and a state exits when it reads 1.
    always_comb begin
        state_next     = state;
        sr_next        = sr;
        bit_cnt_next   = bit_cnt;
        width_cnt_next = width_cnt;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    state_next     = START_HI;
                    sr_next        = tx_data;
                    bit_cnt_next   = '0;
                    width_cnt_next = CNT_W'(START_W);
                end else begin
                    state_next = IDLE;
                end
            end
            START_HI: begin
                if (last_cycle) begin
                    state_next     = GAP;
                    width_cnt_next = CNT_W'(GAP_W);
                end else begin
                    width_cnt_next = width_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (last_cycle) begin
                    if (bit_cnt < BC_W'(N_BITS)) begin
                        state_next     = BIT_HI;
                        width_cnt_next = sr[N_BITS-1] ? CNT_W'(ONE_W) : CNT_W'(ZERO_W);
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    width_cnt_next = width_cnt - CNT_W'(1);
                end
            end
            BIT_HI: begin
                if (last_cycle) begin
                    state_next     = GAP;
                    sr_next        = {sr[N_BITS-2:0], 1'b0};
                    bit_cnt_next   = bit_cnt + BC_W'(1);
                    width_cnt_next = CNT_W'(GAP_W);
                end else begin
                    width_cnt_next = width_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they
    // line up with the state they describe while still coming straight from flops.
    always_ff @(posedge IR_WRITER_CLK) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            width_cnt <= '0;
            ir_signal <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            bit_cnt   <= bit_cnt_next;
            width_cnt <= width_cnt_next;
            ir_signal <= (state_next == START_HI) || (state_next == BIT_HI);
            busy      <= (state_next != IDLE);
            done      <= done_next;
        end
    end

endmodule

// File: doc/ir_writer.md
# ir_writer

Serial IR transmitter that frames a 32-bit word as a sequence of timed high pulses on `ir_signal`: one start pulse, then one pulse per data bit whose width encodes the bit value, with fixed low gaps between pulses. It is the transmit end of the team's pulse-width IR link. It runs on the same 10 kHz tick clock as the IR reader, so pulse widths are in reader counts. It sits between a host/top-level request (`send`, `tx_data`) and the IR emitter pin.

## Interface
- `N_BITS`, 32: data bits per frame.
- `START_W`, 15: start-pulse high width, clocks. Reader decodes ≥14 as start.
- `ONE_W`, 12: high width for a '1' bit, clocks. Reader decodes >9 as high.
- `ZERO_W`, 6: high width for a '0' bit, clocks. Reader decodes 5..8 as low.
- `GAP_W`, 5: low width after every pulse, including the last, clocks.
- `CNT_W`, 5: width of the internal width counter. Must hold max(START_W, ONE_W, ZERO_W, GAP_W).

- `IR_WRITER_CLK`  in  1  10 kHz clock; the same tick rate as the reader clock.
- `reset`  in  1  synchronous, active-high.
- `send`  in  1  frame request; sampled only in IDLE.
- `tx_data`  in  N_BITS  word to send; captured on the accepted `send`.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.
- `ir_signal`  out  1  serial line; idle level 0. Registered output.

## Operation
- Registers: FSM state, shift register `sr[N_BITS-1:0]`, bit counter (0..N_BITS), width counter (CNT_W bits).
- FSM states:
  - IDLE: `ir_signal`=0. On `send`=1, load `sr`←`tx_data`, clear the bit counter, load the width counter with START_W, and go to START_HI.
  - START_HI: `ir_signal`=1 for START_W cycles, then go to GAP.
  - GAP: `ir_signal`=0 for GAP_W cycles.
    - If bits sent < N_BITS, go to BIT_HI and load the width counter with ONE_W if `sr[N_BITS-1]`, else ZERO_W.
    - Otherwise go to IDLE and assert `done`.
  - BIT_HI: `ir_signal`=1 for the loaded width.
    - On the last cycle, shift `sr` left by 1, increment the bit counter, and go to GAP.
- Bit order is MSB first: `tx_data[N_BITS-1]` is sent first.
- The width counter counts down. A state exits on the cycle its counter reads 1. Each state lasts exactly its parameter in clocks.
- `send` while `busy` is ignored. `tx_data` may change after acceptance without effect.
- `send` held high continuously starts the next frame on the first IDLE cycle after `done`. That gives exactly one idle cycle between frames.
- `reset` at any cycle, including mid-pulse, forces IDLE on the next edge and abandons the frame with no `done`.
- Frame length: START_W + GAP_W + Σ(width_i + GAP_W). With defaults this is 372 clocks for all zeros and 564 for all ones.

## Timing
- Reset values: `ir_signal`=0, `busy`=0, `done`=0, state IDLE, `sr`=0, counters 0.
- `send` accepted at edge k gives `busy`=1 and `ir_signal`=1 from cycle k+1. `ir_signal` rises in the cycle after acceptance.
- `ir_signal` is 1 exactly START_W cycles (k+1..k+START_W), then 0 for GAP_W cycles, and so on.
- `done`=1 for exactly the one cycle in which the state returns to IDLE. `busy`=0 in that same cycle.
- `ir_signal` is glitch-free: it is driven from a flop only.

## Test plan
- Reset mid-frame: pulse `reset` during bit 10 of a frame → next cycle `ir_signal`=0, `busy`=0, no `done`. Next `send` starts a clean START_HI of 15 cycles.
- Single frame 0xA5A5_0F0F: measure high widths → first 15, then 32 pulses of 12/6 matching bits 31..0, every gap 5. `done` fires once, after the last gap. Frame length equals the computed total.
- Extremes: 0x0000_0000 → 372-cycle frame, all data pulses 6 wide. 0xFFFF_FFFF → 564 cycles, all 12 wide.
- Busy rejection: assert `send` with 0x1234_5678, then assert `send` with 0xFFFF_FFFF at cycle 100 → the output decodes as 0x1234_5678 only, and `done` fires once.
- Back-to-back: hold `send`=1 with 0x0000_0001 → second frame START_HI begins exactly 2 cycles after the first frame's final GAP ends. `busy` drops for exactly 1 cycle.
- Loopback: connect `ir_signal` to an IR reader on the same clock and send 0xDEAD_BEEF → reader `avail` asserts and `ir_reader_out`=0xDEAD_BEEF.
